// File: rtl/ysyx_23060077_riscv_if_stage_if.sv
// Fetch-stage bundle: EX redirect, instruction-memory request/response,
// and the {pc, inst} handshake towards ID.
interface ysyx_23060077_riscv_if_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;

  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  imem_rsp_err;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INST_WIDTH-1:0] out_inst;
  logic                  out_fault;

  // Fetch stage side.
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_valid, out_pc, out_inst, out_fault,
    input  out_ready
  );

  // Environment side (EX, instruction memory, ID).
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_valid, out_pc, out_inst, out_fault,
    output out_ready
  );
endinterface

// File: rtl/ysyx_23060077_riscv_if_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, response
// held for ID, redirects from EX squash any in-flight response.
module ysyx_23060077_riscv_if_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060077_riscv_if_stage_if.master bus
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  kill;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  fault_q;

  logic                  req_fire;
  logic                  rsp_take;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  unused_redirect_lsb;

  // Targets are word aligned; the low two bits from EX carry no meaning here.
  assign redirect_target     = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign req_fire = (state == ST_REQ) && bus.imem_req_ready;
  // A response is kept only if it belongs to the current path.
  assign rsp_take = (state == ST_WAIT) && bus.imem_rsp_valid && !kill && !bus.redirect_valid;

  assign bus.imem_req_valid = (state == ST_REQ);
  assign bus.imem_req_addr  = pc;
  // Redirect masks the output combinationally so ID never accepts a wrong-path instruction.
  assign bus.out_valid      = (state == ST_HOLD) && !bus.redirect_valid;
  assign bus.out_pc         = pc;
  assign bus.out_inst       = inst_q;
  assign bus.out_fault      = fault_q;

  // Control: state sequencing, PC update and squash tracking.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      case (state)
        ST_RST: state <= ST_REQ;
        ST_REQ: begin
          if (req_fire) state <= ST_WAIT;
          if (bus.redirect_valid) begin
            pc <= redirect_target;
            // The request just issued is for the old path; drop its response.
            if (req_fire) kill <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_valid) begin
            pc <= redirect_target;
            if (bus.imem_rsp_valid) begin
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            kill  <= 1'b0;
            state <= kill ? ST_REQ : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.redirect_valid) begin
            pc    <= redirect_target;
            state <= ST_REQ;
          end else if (bus.out_ready) begin
            pc    <= pc + PC_STEP;
            state <= ST_REQ;
          end
        end
      endcase
    end
  end

  // Datapath: capture the accepted response for presentation to ID.
  // NOTE: these data registers are reset because out_inst/out_fault are
  // visible to ID straight out of reset and must read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else if (rsp_take) begin
      inst_q  <= bus.imem_rsp_data;
      fault_q <= bus.imem_rsp_err;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_riscv_if_stage.sv
// Self-checking bench for the fetch stage: directed scenarios followed by a
// randomized run, all checked against a program-order reference model.
module tb_ysyx_23060077_riscv_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk;
  logic rst_n;

  ysyx_23060077_riscv_if_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  ysyx_23060077_riscv_if_stage #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model state.
  logic [31:0] fault_addr = 32'h8000_0304;
  bit          pend       = 1'b0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;
  int          rsp_delay  = 1;

  // Reference model: the PC of the next instruction ID should accept.
  bit          model_on = 1'b0;
  logic [31:0] exp_pc   = RESET_PC;
  int          accepted = 0;

  // Request stability tracking.
  bit          prev_stall = 1'b0;
  bit          prev_rdr   = 1'b0;
  logic [31:0] prev_tgt   = '0;
  logic [31:0] prev_addr  = '0;

  // Sampled outputs of the most recent cycle.
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_out_valid;
  logic [31:0] s_out_pc;
  logic [31:0] s_out_inst;
  logic        s_out_fault;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a << 3) ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == fault_addr) || (a[8:2] == 7'h55);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample #1 later,
  // run the memory and reference models, then advance to the next falling edge.
  task automatic cycle(input bit rdr, input logic [31:0] tgt, input bit rdy, input bit ordy);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = tgt;
    bus.imem_req_ready = rdy;
    bus.out_ready      = ordy;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_err   = 1'b0;
    if (pend) begin
      if (pend_cnt == 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(pend_addr);
        bus.imem_rsp_err   = mem_err(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_out_valid = bus.out_valid;
    s_out_pc    = bus.out_pc;
    s_out_inst  = bus.out_inst;
    s_out_fault = bus.out_fault;

    if (model_on) begin
      if (rdr) check("out_masked", s_out_valid, 1'b0);
      if (s_req_valid) check("one_outstanding", pend, 1'b0);
      if (prev_stall && rst_n) begin
        check("req_hold_valid", s_req_valid, 1'b1);
        check("req_hold_addr", s_req_addr, prev_rdr ? (prev_tgt & ~32'h3) : prev_addr);
      end
      if (s_out_valid && ordy) begin
        check("out_pc", s_out_pc, exp_pc);
        check("out_inst", s_out_inst, mem_data(exp_pc));
        check("out_fault", s_out_fault, mem_err(exp_pc));
        accepted++;
      end
      if (s_req_valid && rdy && !rdr) check("req_addr", s_req_addr, exp_pc);
      if (rdr) exp_pc = tgt & ~32'h3;
      else if (s_out_valid && ordy) exp_pc = exp_pc + 32'd4;
    end

    prev_stall = s_req_valid && !rdy;
    prev_rdr   = rdr;
    prev_tgt   = tgt;
    prev_addr  = s_req_addr;

    if (s_req_valid && rdy) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = s_req_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.out_ready      = 1'b0;
    @(negedge clk);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("rst_req_valid", s_req_valid, 1'b0);
    check("rst_out_valid", s_out_valid, 1'b0);
    check("rst_out_pc", s_out_pc, RESET_PC);
    check("rst_out_inst", s_out_inst, 32'h0);
    check("rst_out_fault", s_out_fault, 1'b0);

    // Boot: first request one cycle after release, output two cycles later.
    rst_n    = 1'b1;
    model_on = 1'b1;
    exp_pc   = RESET_PC;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("boot_idle", s_req_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("boot_req_valid", s_req_valid, 1'b1);
    check("boot_req_addr", s_req_addr, RESET_PC);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("boot_wait_out", s_out_valid, 1'b0);

    // Backpressure in HOLD for five cycles.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("bp_out_valid", s_out_valid, 1'b1);
      check("bp_out_pc", s_out_pc, RESET_PC);
      check("bp_out_inst", s_out_inst, mem_data(RESET_PC));
      check("bp_no_req", s_req_valid, 1'b0);
    end
    cycle(1'b0, '0, 1'b1, 1'b1);
    rsp_delay = 2;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("seq_req_addr", s_req_addr, 32'h8000_0004);

    // Redirect while waiting; the stale response must be dropped.
    cycle(1'b1, 32'h8000_0103, 1'b1, 1'b0);
    check("wait_rdr_out", s_out_valid, 1'b0);
    rsp_delay = 1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("stale_drop_out", s_out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("rdr_req_addr", s_req_addr, 32'h8000_0100);

    // Redirect coincident with the response.
    cycle(1'b1, 32'h8000_0200, 1'b1, 1'b0);
    check("coinc_out", s_out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("coinc_req_valid", s_req_valid, 1'b1);
    check("coinc_req_addr", s_req_addr, 32'h8000_0200);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Redirect in HOLD with out_ready high: no fire, pc becomes the target.
    cycle(1'b1, 32'h8000_0300, 1'b1, 1'b1);
    check("hold_rdr_out", s_out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("hold_rdr_addr", s_req_addr, 32'h8000_0300);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("after_rdr_pc", s_out_pc, 32'h8000_0300);

    // Access fault flows through; fetch continues at pc+4.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("fault_flag", s_out_fault, 1'b1);
    check("fault_pc", s_out_pc, 32'h8000_0304);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("fault_next_addr", s_req_addr, 32'h8000_0308);

    // Killed request from REQ+redirect, then wrap of the PC.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("kill_drop_out", s_out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("wrap_req_addr", s_req_addr, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("wrap_out_pc", s_out_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("wrap_stall_addr", s_req_addr, 32'h0000_0000);
    end
    cycle(1'b1, 32'h8000_0400, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_rdr_addr", s_req_addr, 32'h8000_0400);

    // Reset asserted mid-WAIT; the late response must be ignored.
    rsp_delay = 2;
    cycle(1'b0, '0, 1'b1, 1'b0);
    rst_n  = 1'b0;
    exp_pc = RESET_PC;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("midrst_pc", s_out_pc, RESET_PC);
    check("midrst_req", s_req_valid, 1'b0);
    rst_n     = 1'b1;
    rsp_delay = 1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("late_rsp_out", s_out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("midrst_req_addr", s_req_addr, RESET_PC);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("midrst_inst", s_out_inst, mem_data(RESET_PC));

    // Randomized traffic against the reference model.
    accepted = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        rdr;
      logic [31:0] tgt;
      rdr = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rsp_delay = $urandom_range(1, 3);
      cycle(rdr, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    check("random_progress", accepted > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
